// File: rtl/ysyx_23060061_alu_arb.sv
// ysyx_23060061_alu_arb: two-port round-robin arbiter and sequencer
// that shares the execute-stage combinational ALU.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   reqN_valid/ready      request handshake (N = 0 EXU, 1 CSR/AGU)
//   reqN_a/b/op           operands and 4-bit op code
//   rspN_valid/ready      response handshake, owner port only
//   rspN_data/err         shared result register and illegal-op flag
//   alu_a/b/op, alu_out   connection to the shared ALU
//   busy                  high whenever not idle
module ysyx_23060061_alu_arb #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] OP_MAX = 4'b1100;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       op_code;
    logic [WIDTH-1:0] res;
    logic             err;
    logic             owner;
    logic             last_grant;

    logic             idle;
    logic             grant;
    logic             acc0;
    logic             acc1;
    logic             rsp_done;

    assign idle = (state == IDLE);

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = idle & req0_valid & ~grant;
    assign req1_ready = idle & req1_valid & grant;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;

    assign alu_a  = op_a;
    assign alu_b  = op_b;
    assign alu_op = op_code;

    assign rsp0_valid = (state == RESP) & ~owner;
    assign rsp1_valid = (state == RESP) & owner;
    assign rsp0_data  = res;
    assign rsp1_data  = res;
    assign rsp0_err   = err;
    assign rsp1_err   = err;

    // Only the owner's ready can retire the response.
    assign rsp_done = owner ? rsp1_ready : rsp0_ready;

    assign busy = ~idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= 4'b0000;
            res        <= '0;
            err        <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (acc0) begin
                        op_a       <= req0_a;
                        op_b       <= req0_b;
                        op_code    <= req0_op;
                        owner      <= 1'b0;
                        last_grant <= 1'b0;
                        state      <= EXEC;
                    end else if (acc1) begin
                        op_a       <= req1_a;
                        op_b       <= req1_b;
                        op_code    <= req1_op;
                        owner      <= 1'b1;
                        last_grant <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_code <= OP_MAX) begin
                        res <= alu_out;
                        err <= 1'b0;
                    end else begin
                        res <= '0;
                        err <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060061_alu_arb.sv
// tb_ysyx_23060061_alu_arb: directed bench for the shared-ALU arbiter
// with a behavioural ALU on the alu_* side.
module tb_ysyx_23060061_alu_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp0_err;
    logic        rsp1_valid, rsp1_ready, rsp1_err;
    logic [31:0] rsp0_data, rsp1_data;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_23060061_alu_arb #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .busy(busy)
    );

    // Behavioural shared ALU.
    always_comb begin
        alu_out = 32'hDEAD_BEEF;
        case (alu_op)
            4'd0:  alu_out = alu_a + alu_b;
            4'd1:  alu_out = alu_a - alu_b;
            4'd2:  alu_out = alu_a & alu_b;
            4'd3:  alu_out = alu_a | alu_b;
            4'd4:  alu_out = alu_a ^ alu_b;
            4'd5:  alu_out = alu_a << alu_b[4:0];
            4'd6:  alu_out = alu_a >> alu_b[4:0];
            4'd7:  alu_out = $signed(alu_a) >>> alu_b[4:0];
            4'd8:  alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
            4'd9:  alu_out = {31'b0, alu_a < alu_b};
            4'd10: alu_out = alu_b;
            4'd11: alu_out = alu_a;
            4'd12: alu_out = {31'b0, alu_a == alu_b};
            default: alu_out = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        string       name;
        bit          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic run_txn(input vec_t v);
        int n;
        logic rdy;
        @(negedge clk);
        if (v.port) begin
            req1_valid = 1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
        end else begin
            req0_valid = 1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
        end
        #1;
        n = 0;
        rdy = v.port ? req1_ready : req0_ready;
        while (!rdy && n < 10) begin
            @(negedge clk); #1; n++;
            rdy = v.port ? req1_ready : req0_ready;
        end
        chk({v.name, "_req_ready"}, {31'b0, rdy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        #1;
        chk({v.name, "_exec_busy"}, {31'b0, busy}, 32'd1);
        chk({v.name, "_alu_a"}, alu_a, v.a);
        chk({v.name, "_alu_b"}, alu_b, v.b);
        chk({v.name, "_alu_op"}, {28'b0, alu_op}, {28'b0, v.op});
        chk({v.name, "_exec_rsp"}, {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        @(negedge clk); #1;
        chk({v.name, "_rsp_valid"}, {30'b0, rsp1_valid, rsp0_valid},
            v.port ? 32'd2 : 32'd1);
        chk({v.name, "_data"}, v.port ? rsp1_data : rsp0_data, v.exp_data);
        chk({v.name, "_err"}, {31'b0, v.port ? rsp1_err : rsp0_err},
            {31'b0, v.exp_err});
        if (v.port) rsp1_ready = 1; else rsp0_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp0_ready = 0; rsp1_ready = 0;
        #1;
        chk({v.name, "_done_busy"}, {31'b0, busy}, 32'd0);
    endtask

    vec_t vecs[9];
    vec_t post;

    initial begin
        vecs[0] = '{"add5_7",  1'b0, 32'd5, 32'd7, 4'd0, 32'd12, 1'b0};
        vecs[1] = '{"sub3_5",  1'b1, 32'd3, 32'd5, 4'd1, 32'hFFFF_FFFE, 1'b0};
        vecs[2] = '{"and",     1'b0, 32'hF0F0, 32'h0FF0, 4'd2, 32'h00F0, 1'b0};
        vecs[3] = '{"sll",     1'b1, 32'd1, 32'd4, 4'd5, 32'd16, 1'b0};
        vecs[4] = '{"sra",     1'b0, 32'h8000_0000, 32'd4, 4'd7,
                    32'hF800_0000, 1'b0};
        vecs[5] = '{"sltu",    1'b1, 32'hFFFF_FFFF, 32'd1, 4'd9, 32'd0, 1'b0};
        vecs[6] = '{"eq_max",  1'b0, 32'd2, 32'd2, 4'd12, 32'd1, 1'b0};
        vecs[7] = '{"ill_e",   1'b0, 32'd5, 32'd7, 4'd14, 32'd0, 1'b1};
        vecs[8] = '{"ill_f",   1'b1, 32'd5, 32'd7, 4'd15, 32'd0, 1'b1};

        idle_inputs();
        rst = 1;
        @(negedge clk); #1;
        chk("rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
        chk("rst_rsp", {28'b0, rsp1_valid, rsp0_valid, rsp1_err, rsp0_err},
            32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_alu", alu_a | alu_b | {28'b0, alu_op}, 32'd0);
        chk("rst_data", rsp0_data | rsp1_data, 32'd0);
        @(negedge clk);
        rst = 0;

        // Tie after reset: grants alternate 0,1,0,1 every 3 cycles.
        @(negedge clk);
        req0_valid = 1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'd0;
        req1_valid = 1; req1_a = 32'd2; req1_b = 32'd2; req1_op = 4'd0;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c % 3 == 0)
                chk($sformatf("tie_grant%0d", c / 3),
                    {30'b0, req1_ready, req0_ready},
                    ((c / 3) % 2 == 0) ? 32'd1 : 32'd2);
            else
                chk($sformatf("tie_hold%0d", c),
                    {30'b0, req1_ready, req0_ready}, 32'd0);
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("tie_end_busy", {31'b0, busy}, 32'd0);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Back-pressure on port 1 while port 0 waits.
        @(negedge clk);
        req1_valid = 1; req1_a = 32'd3; req1_b = 32'd5; req1_op = 4'd1;
        #1;
        chk("bp_req1_ready", {31'b0, req1_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 0; req0_valid = 1;
        req0_a = 32'd8; req0_b = 32'd8; req0_op = 4'd0;
        #1;
        chk("bp_exec_req0", {31'b0, req0_ready}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 4) rsp1_ready = 1;
            #1;
            chk($sformatf("bp_valid%0d", c), {31'b0, rsp1_valid}, 32'd1);
            chk($sformatf("bp_data%0d", c), rsp1_data, 32'hFFFF_FFFE);
            chk($sformatf("bp_busy%0d", c), {31'b0, busy}, 32'd1);
            chk($sformatf("bp_req0_%0d", c), {31'b0, req0_ready}, 32'd0);
        end
        @(negedge clk);
        rsp1_ready = 0;
        #1;
        chk("bp_after_rsp", {31'b0, rsp1_valid}, 32'd0);
        chk("bp_req0_granted", {31'b0, req0_ready}, 32'd1);
        req0_valid = 0;
        #1;
        chk("bp_withdraw", {31'b0, req0_ready}, 32'd0);

        // Non-owner ready must not retire the response.
        @(negedge clk);
        req0_valid = 1; req0_a = 32'd10; req0_b = 32'd20; req0_op = 4'd0;
        rsp1_ready = 1;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk($sformatf("nonown_valid%0d", c),
                {30'b0, rsp1_valid, rsp0_valid}, 32'd1);
            chk($sformatf("nonown_data%0d", c), rsp0_data, 32'd30);
        end
        rsp0_ready = 1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("nonown_done", {31'b0, busy}, 32'd0);

        // Reset while in EXEC drops the operation.
        @(negedge clk);
        req0_valid = 1; req0_a = 32'd9; req0_b = 32'd9; req0_op = 4'd0;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        #1;
        chk("rexec_busy", {31'b0, busy}, 32'd1);
        rst = 1;
        #1;
        chk("rexec_busy0", {31'b0, busy}, 32'd0);
        chk("rexec_alu", alu_a | alu_b | {28'b0, alu_op}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk($sformatf("rexec_norsp%0d", c),
                {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        end
        rst = 0;
        post = '{"post_rst", 1'b1, 32'd1, 32'd2, 4'd0, 32'd3, 1'b0};
        run_txn(post);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
